spi_ram_ctrl: RTL and testbench

Command-decoding single-port RAM that sits directly downstream of the SPI slave. Consumes the slave's 10-bit `rx_data`/`rx_valid` words, interprets bits [9:8] as a command (write address, write data, read address, read data), and returns read data to the slave on `tx_data`/`tx_valid` for shifting out on MISO. Shares the SPI clock domain with the slave.

---
 rtl/spi_ram_pkg.sv | 26 ++
 rtl/spi_ram_mem.sv | 29 ++
 rtl/spi_ram_ctrl.sv | 135 +++++++++++++
 tb/tb_spi_ram_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: command encodings, FSM state type and defaults shared by the
// SPI RAM controller and its storage array.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Default number of cycles tx_valid is held per read.
    localparam int TX_HOLD_DEF = 8;

    // Hold counter width; covers the full 1..15 TX_HOLD range.
    localparam int CNT_W = 4;

    // Command field of a 10-bit SPI word.
    function automatic logic [1:0] cmd_of(input logic [9:0] word);
        return word[9:8];
    endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: 8-bit wide storage array with a single port. Writes commit on
// the rising edge of sclk; the read path is combinational so the controller
// can register the addressed word at the same edge that samples a read.
// Contents are never reset.
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 sclk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem [MEM_DEPTH];

    // Commit a write at the sampling edge.
    always_ff @(posedge sclk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command-decoding RAM behind an SPI slave. Decodes 10-bit
// words (cmd in [9:8]) into address loads, memory writes and reads; read
// data is presented on tx_data with tx_valid held for TX_HOLD cycles.
// Optional feature macro: SPI_RAM_AUTOINC_EN -- post-increment wr_addr on
// each WR_DATA and rd_addr on each RD_DATA, wrapping modulo MEM_DEPTH.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int TX_HOLD   = TX_HOLD_DEF
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(TX_HOLD - 1);
`ifdef SPI_RAM_AUTOINC_EN
    localparam logic [ADDR_SIZE-1:0] ADDR_STEP = ADDR_SIZE'(1);
`endif

    logic [1:0]           cmd;
    logic                 is_wr_addr;
    logic                 is_wr_data;
    logic                 is_rd_addr;
    logic                 is_rd_data;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [7:0]           mem_rdata;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [7:0]           tx_data_nxt;
    logic                 tx_valid_nxt;

    assign cmd        = cmd_of(din);
    assign is_wr_addr = rx_valid && (cmd == CMD_WR_ADDR);
    assign is_wr_data = rx_valid && (cmd == CMD_WR_DATA);
    assign is_rd_addr = rx_valid && (cmd == CMD_RD_ADDR);
    assign is_rd_data = rx_valid && (cmd == CMD_RD_DATA);

    // Single port: a write borrows the port, otherwise it points at rd_addr.
    assign mem_addr = is_wr_data ? wr_addr : rd_addr;

    spi_ram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .sclk  (sclk),
        .we    (is_wr_data),
        .addr  (mem_addr),
        .wdata (din[7:0]),
        .rdata (mem_rdata)
    );

    // Address registers: explicit loads, plus optional post-increment.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else begin
            if (is_wr_addr) begin
                wr_addr <= din[ADDR_SIZE-1:0];
            end
`ifdef SPI_RAM_AUTOINC_EN
            else if (is_wr_data) begin
                wr_addr <= wr_addr + ADDR_STEP;
            end
`endif
            if (is_rd_addr) begin
                rd_addr <= din[ADDR_SIZE-1:0];
            end
`ifdef SPI_RAM_AUTOINC_EN
            else if (is_rd_data) begin
                rd_addr <= rd_addr + ADDR_STEP;
            end
`endif
        end
    end

    // FSM state, hold counter and registered read outputs.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            tx_data  <= tx_data_nxt;
            tx_valid <= tx_valid_nxt;
        end
    end

    // Next state: a read (re)starts SEND from any state; SEND times out on cnt.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        tx_data_nxt  = tx_data;
        tx_valid_nxt = tx_valid;
        if (is_rd_data) begin
            state_nxt    = SEND;
            cnt_nxt      = HOLD_LOAD;
            tx_data_nxt  = mem_rdata;
            tx_valid_nxt = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_valid_nxt = 1'b0;
                end
                SEND: begin
                    if (cnt == '0) begin
                        state_nxt    = IDLE;
                        tx_valid_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    tx_valid_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: randomized and directed stimulus for spi_ram_ctrl, checked
// against a reference model of memory, address pointers and the remaining
// number of cycles a read stays visible.
module tb_spi_ram_ctrl;

    localparam int TX_HOLD = 8;

    logic       sclk;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int total;
    int bad;

    // Reference model state.
    logic [7:0] m_mem [256];
    logic [7:0] m_wr;
    logic [7:0] m_rd;
    logic [7:0] m_data;
    int         m_left;

    spi_ram_ctrl #(
        .MEM_DEPTH (256),
        .ADDR_SIZE (8),
        .TX_HOLD   (TX_HOLD)
    ) dut (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Present one word for one clock edge and advance the model to match.
    task automatic step(input logic v, input logic [9:0] d);
        rx_valid = v;
        din      = d;
        @(posedge sclk);
        if (m_left > 0) m_left--;
        if (v) begin
            case (d[9:8])
                2'b00: m_wr = d[7:0];
                2'b01: begin
                    m_mem[m_wr] = d[7:0];
`ifdef SPI_RAM_AUTOINC_EN
                    m_wr = m_wr + 8'd1;
`endif
                end
                2'b10: m_rd = d[7:0];
                default: begin
                    m_data = m_mem[m_rd];
                    m_left = TX_HOLD;
`ifdef SPI_RAM_AUTOINC_EN
                    m_rd = m_rd + 8'd1;
`endif
                end
            endcase
        end
        #1;
    endtask

    task automatic model_reset();
        m_wr   = 8'h00;
        m_rd   = 8'h00;
        m_left = 0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        din      = '0;
        model_reset();
        repeat (2) @(posedge sclk);
        #1;
        total++;
        if (tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_tx_valid got=%b want=0", tx_valid);
        end
        total++;
        if (tx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_tx_data got=%h want=00", tx_data);
        end
        @(negedge sclk);
        rst_n = 1'b1;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 256; i++) begin
            step(1'b1, {2'b00, 8'(i)});
            step(1'b1, {2'b01, 8'($urandom_range(0, 255))});
        end
        repeat (TX_HOLD + 2) step(1'b0, 10'h000);
    endtask

    task automatic test_basic_read();
        int hi;
        step(1'b1, 10'h03C);
        step(1'b1, 10'h1A5);
        step(1'b1, 10'h23C);
        step(1'b1, 10'h300);
        total++;
        if (tx_data !== 8'hA5) begin
            bad++;
            $display("FAIL basic_data got=%h want=A5", tx_data);
        end
        hi = (tx_valid === 1'b1) ? 1 : 0;
        for (int i = 0; i < TX_HOLD + 2; i++) begin
            step(1'b0, 10'h000);
            if (tx_valid === 1'b1) hi++;
        end
        total++;
        if (hi != TX_HOLD) begin
            bad++;
            $display("FAIL basic_hold_cycles got=%0d want=%0d", hi, TX_HOLD);
        end
        total++;
        if (tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_valid_end got=%b want=0", tx_valid);
        end
    endtask

    task automatic test_back_to_back();
        int hi;
        step(1'b1, 10'h005);
        step(1'b1, 10'h111);
        step(1'b1, 10'h006);
        step(1'b1, 10'h122);
        repeat (TX_HOLD + 2) step(1'b0, 10'h000);
        step(1'b1, 10'h205);
        step(1'b1, 10'h300);
        for (int c = 1; c <= 3; c++) begin
            total++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
                bad++;
                $display("FAIL b2b_first cyc=%0d got=%b/%h want=1/11", c, tx_valid, tx_data);
            end
            if (c == 1) step(1'b0, 10'h000);
            if (c == 2) step(1'b1, 10'h206);
            if (c == 3) step(1'b1, 10'h300);
        end
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h22) begin
            bad++;
            $display("FAIL b2b_second got=%b/%h want=1/22", tx_valid, tx_data);
        end
        hi = 1;
        for (int i = 0; i < TX_HOLD + 2; i++) begin
            step(1'b0, 10'h000);
            if (tx_valid === 1'b1) begin
                hi++;
                total++;
                if (tx_data !== 8'h22) begin
                    bad++;
                    $display("FAIL b2b_hold_data got=%h want=22", tx_data);
                end
            end
        end
        total++;
        if (hi != TX_HOLD) begin
            bad++;
            $display("FAIL b2b_hold_cycles got=%0d want=%0d", hi, TX_HOLD);
        end
    endtask

    task automatic test_write_during_send();
        logic [7:0] sent;
        logic [7:0] nv;
        logic [7:0] nv2;
        step(1'b1, 10'h240);
        step(1'b1, 10'h300);
        sent = m_mem[8'h40];
        nv   = m_mem[8'h41] ^ 8'hFF;
        step(1'b1, 10'h041);
        step(1'b1, {2'b01, nv});
        step(1'b1, 10'h260);
        total++;
        if (tx_valid !== 1'b1 || tx_data !== sent) begin
            bad++;
            $display("FAIL wr_in_send_hold got=%b/%h want=1/%h", tx_valid, tx_data, sent);
        end
        repeat (TX_HOLD + 2) step(1'b0, 10'h000);
        step(1'b1, 10'h241);
        step(1'b1, 10'h300);
        total++;
        if (tx_valid !== 1'b1 || tx_data !== nv) begin
            bad++;
            $display("FAIL wr_in_send_readback got=%b/%h want=1/%h", tx_valid, tx_data, nv);
        end
        nv2 = m_mem[8'h50] + 8'h33;
        step(1'b1, 10'h050);
        step(1'b1, 10'h250);
        step(1'b1, {2'b01, nv2});
        step(1'b1, 10'h300);
        total++;
        if (tx_data !== nv2) begin
            bad++;
            $display("FAIL wr_then_rd got=%h want=%h", tx_data, nv2);
        end
        repeat (TX_HOLD + 2) step(1'b0, 10'h000);
    endtask

    task automatic test_no_valid();
        step(1'b1, 10'h077);
        step(1'b1, 10'h15A);
        step(1'b1, 10'h077);
        repeat (3) step(1'b0, 10'h1FF);
        step(1'b1, 10'h277);
        step(1'b1, 10'h300);
        total++;
        if (tx_data !== 8'h5A) begin
            bad++;
            $display("FAIL no_valid_write got=%h want=5A", tx_data);
        end
        repeat (TX_HOLD + 2) step(1'b0, 10'h000);
    endtask

    task automatic test_random();
        logic       v;
        logic [9:0] d;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            d = 10'($urandom_range(0, 1023));
            step(v, d);
            total++;
            if (tx_valid !== (m_left > 0)) begin
                bad++;
                $display("FAIL rand_valid i=%0d got=%b want=%b", i, tx_valid, (m_left > 0));
            end
            if (m_left > 0) begin
                total++;
                if (tx_data !== m_data) begin
                    bad++;
                    $display("FAIL rand_data i=%0d got=%h want=%h", i, tx_data, m_data);
                end
            end
        end
        repeat (TX_HOLD + 2) step(1'b0, 10'h000);
    endtask

    task automatic test_reset_mid_send();
        logic [7:0] at0;
        step(1'b1, 10'h2A0);
        step(1'b1, 10'h300);
        step(1'b0, 10'h000);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            bad++;
            $display("FAIL async_reset got=%b/%h want=0/00", tx_valid, tx_data);
        end
        model_reset();
        @(posedge sclk);
        @(negedge sclk);
        rst_n = 1'b1;
        at0 = m_mem[8'h00];
        step(1'b1, 10'h300);
        total++;
        if (tx_valid !== 1'b1 || tx_data !== at0) begin
            bad++;
            $display("FAIL post_reset_read got=%b/%h want=1/%h", tx_valid, tx_data, at0);
        end
        repeat (TX_HOLD + 2) step(1'b0, 10'h000);
    endtask

`ifdef SPI_RAM_AUTOINC_EN
    task automatic test_autoinc();
        step(1'b1, 10'h0FF);
        step(1'b1, 10'h1AA);
        step(1'b1, 10'h1BB);
        step(1'b1, 10'h2FF);
        step(1'b1, 10'h300);
        total++;
        if (tx_data !== 8'hAA) begin
            bad++;
            $display("FAIL autoinc_first got=%h want=AA", tx_data);
        end
        step(1'b1, 10'h300);
        total++;
        if (tx_data !== 8'hBB) begin
            bad++;
            $display("FAIL autoinc_wrap got=%h want=BB", tx_data);
        end
        repeat (TX_HOLD + 2) step(1'b0, 10'h000);
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        init_mem();
        test_basic_read();
        test_back_to_back();
        test_write_during_send();
        test_no_valid();
        test_random();
        test_reset_mid_send();
`ifdef SPI_RAM_AUTOINC_EN
        test_autoinc();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
